// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Accumulation stage that sits behind the 8x8 unsigned multiplier. It sums a
// programmed number of unsigned products into a wide accumulator, tracks a
// sticky carry-out, and offers the finished sum on an output handshake.
//
// Ports
//   clk        : single clock, rising-edge active
//   rst_n      : synchronous active-low reset
//   start      : begin a new accumulation (sampled only in IDLE)
//   len        : number of products to sum (sampled with start)
//   in_valid   : in_prod carries a product this cycle
//   in_ready   : block accepts a product this cycle (ACCUM only)
//   in_prod    : unsigned product from the multiplier
//   out_valid  : out_acc/out_ovf hold a completed result (HOLD only)
//   out_ready  : consumer takes the result this cycle
//   out_acc    : unsigned sum, modulo 2^ACC_W
//   out_ovf    : sticky carry out of bit ACC_W-1 during this accumulation
//   busy       : high in ACCUM or HOLD
//
// ACC_W must be at least PROD_W so each product zero-extends into the
// accumulator. Every output is decoded from registered state only.
// ---------------------------------------------------------------------------
module product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;

    // One bit wider than the accumulator so the carry out is visible.
    logic [ACC_W:0]     sum;

    assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};

    // NOTE: every _d signal gets its hold value first, so paths that do not
    // assign it cannot infer a latch.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    remaining_d = len;
                    // A zero-length job has nothing to sum: present 0 at once.
                    state_d     = (len == '0) ? ST_HOLD : ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                // in_ready is constant 1 here, so in_valid alone is a transfer.
                if (in_valid) begin
                    acc_d       = sum[ACC_W-1:0];
                    ovf_d       = ovf_q | sum[ACC_W];
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    // Result registers are left untouched in IDLE so the last sum stays visible.
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

endmodule
